// File: rtl/sram_word_sequencer.sv
// Single-port access sequencer for the word-cell array: one request at a time,
// one-hot wordline strobe framed by setup/recover cycles, registered read capture.
module sram_word_sequencer #(
  parameter int WORDS  = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [WORDS-1:0]  word_lines,
  output logic              rw,
  output logic [WIDTH-1:0]  word,
  output logic [WIDTH-1:0]  bit_lines_seed,
  input  logic [WIDTH-1:0]  bit_lines_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } seqState_t;

  seqState_t         state;
  logic [ADDR_W-1:0] addrLatch;
  logic [WORDS-1:0]  addrDecode;
  logic              addrInRange;

  // Out-of-range addresses decode to all-zero, so no wordline ever fires for them.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : gen_decode
      assign addrDecode[gi] = (addrLatch == ADDR_W'(gi));
    end
  endgenerate

  assign addrInRange    = (32'(addrLatch) < 32'(WORDS));
  assign bit_lines_seed = '0;

  // rw and word are loaded at accept and cleared on the RECOVER->IDLE edge only,
  // so they are stable on both wordline edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addrLatch  <= '0;
      req_ready  <= 1'b1;
      word_lines <= '0;
      rw         <= 1'b0;
      word       <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addrLatch <= req_addr;
            rw        <= req_rw;
            word      <= req_rw ? req_wdata : '0;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          word_lines <= addrDecode;
          state      <= STROBE;
        end
        STROBE: begin
          word_lines <= '0;
          if (!rw) begin
            rsp_rdata <= addrInRange ? bit_lines_out : '0;
          end
          rsp_valid <= !rw || !addrInRange;
          rsp_err   <= !addrInRange;
          state     <= RECOVER;
        end
        RECOVER: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rw        <= 1'b0;
          word      <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
